// File: rtl/apb_spi_master_n.sv
// APB-slave SPI master: parametrised chip selects, frame width, TX/RX FIFOs,
// programmable SCK divider, all four SPI modes, bursts and a completion IRQ.
`timescale 1ns/1ps
module apb_spi_master_n #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8
) (
  input  logic                  i_PCLK,
  input  logic                  i_PRESETn,
  input  logic                  i_PSEL,
  input  logic                  i_PENABLE,
  input  logic                  i_PWRITE,
  input  logic [15:0]           i_PADDR,
  input  logic [DATA_W-1:0]     i_PWDATA,
  input  logic [9:0]            i_BASE_ADDR,
  output logic [DATA_W-1:0]     o_PRDATA,
  output logic                  o_PREADY,
  output logic                  o_PSLVERR,
  output logic                  o_SCK,
  output logic                  o_MOSI,
  input  logic                  i_MISO,
  output logic [NUM_SLAVES-1:0] o_CS_N,
  output logic                  o_IRQ
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(2 * DATA_W);
  localparam logic [HW-1:0] LAST_HALF = HW'(2 * DATA_W - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [6:0]    NS7       = 7'(NUM_SLAVES);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL} state_t;

  // Registers
  state_t                state_q;
  logic [DIV_W-1:0]      tmr_q;
  logic [HW-1:0]         half_q;
  logic                  sck_q, mosi_q;
  logic [NUM_SLAVES-1:0] cs_n_q;
  logic [DATA_W-1:0]     txsh_q, rxsh_q;
  logic                  cpol_q, cpha_q, ovf_q, done_q;
  logic [5:0]            slv_q;
  logic [DIV_W-1:0]      div_q;

  logic [DATA_W-1:0]     tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]     rx_mem [FIFO_DEPTH];
  logic [AW-1:0]         tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [AW:0]           tx_cnt_q, rx_cnt_q;

  // Bus decode
  logic       access, wr_acc, rd_acc;
  logic [3:0] off;
  assign access = i_PSEL & i_PENABLE & (i_PADDR[15:6] == i_BASE_ADDR);
  assign wr_acc = access & i_PWRITE;
  assign rd_acc = access & ~i_PWRITE;
  assign off    = i_PADDR[5:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^i_PADDR[1:0];

  logic busy, tx_empty, tx_full, rx_empty, rx_full;
  assign busy     = (state_q != S_IDLE);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);

  logic idx_bad, cfg_ok, div_ok, cmd_wr, cmd_err, flush, start_go, stat_rd;
  logic tx_push, tx_pop, rx_push, rx_pop;
  assign idx_bad  = ({1'b0, i_PWDATA[7:2]} >= NS7);
  assign cfg_ok   = wr_acc & (off == 4'd0) & ~busy & ~idx_bad;
  assign div_ok   = wr_acc & (off == 4'd2) & ~busy;
  assign cmd_wr   = wr_acc & (off == 4'd3);
  assign cmd_err  = cmd_wr & busy & (i_PWDATA[1] | i_PWDATA[0]);
  // FLUSH takes priority over START when both are requested together
  assign flush    = cmd_wr & ~busy & i_PWDATA[0];
  assign start_go = cmd_wr & ~busy & i_PWDATA[1] & ~i_PWDATA[0] & ~tx_empty;
  assign stat_rd  = rd_acc & (off == 4'd0);
  assign tx_push  = wr_acc & (off == 4'd1) & ~tx_full;
  assign rx_pop   = rd_acc & (off == 4'd1) & ~rx_empty;

  // Shift timing
  logic tmr_end, trail_end, load_go, sample_now, shift_now;
  logic [DATA_W-1:0] tx_head;
  assign tmr_end    = (tmr_q == div_q);
  assign trail_end  = (state_q == S_TRAIL) & tmr_end;
  assign load_go    = start_go | (trail_end & ~tx_empty);
  assign tx_pop     = load_go;
  assign rx_push    = trail_end & ~rx_full;
  // Even half-period ends are leading SCK edges, odd ones are trailing
  assign sample_now = cpha_q ? half_q[0] : ~half_q[0];
  assign shift_now  = ~sample_now;
  assign tx_head    = tx_mem[tx_rp_q];

  // One-hot chip-select decode of the configured slave index
  logic [NUM_SLAVES-1:0] sel_dec;
  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
      assign sel_dec[gi] = (slv_q == 6'(gi));
    end
  endgenerate

  // Status word
  logic [DATA_W-1:0] status;
  always_comb begin
    status      = '0;
    status[6:0] = {done_q, ovf_q, rx_full, rx_empty, tx_full, tx_empty, busy};
  end

  // Read data mux, only driven during a read access phase
  always_comb begin
    o_PRDATA = '0;
    if (rd_acc) begin
      case (off)
        4'd0:    o_PRDATA = status;
        4'd1:    o_PRDATA = rx_empty ? '0 : rx_mem[rx_rp_q];
        4'd2:    o_PRDATA = DATA_W'(div_q);
        default: o_PRDATA = '0;
      endcase
    end
  end

  // Error response for illegal accesses
  always_comb begin
    o_PSLVERR = 1'b0;
    if (access) begin
      case (off)
        4'd0:    o_PSLVERR = i_PWRITE & (busy | idx_bad);
        4'd1:    o_PSLVERR = i_PWRITE ? tx_full : rx_empty;
        4'd2:    o_PSLVERR = i_PWRITE & busy;
        4'd3:    o_PSLVERR = cmd_err;
        default: o_PSLVERR = 1'b0;
      endcase
    end
  end

  assign o_PREADY = access;
  assign o_SCK    = sck_q;
  assign o_MOSI   = mosi_q;
  assign o_CS_N   = cs_n_q;
  assign o_IRQ    = done_q | ovf_q;

  // Configuration, divider and sticky status flags
  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      slv_q  <= '0;
      div_q  <= DIV_W'(1);
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (cfg_ok) begin
        cpol_q <= i_PWDATA[1];
        cpha_q <= i_PWDATA[0];
        slv_q  <= i_PWDATA[7:2];
      end
      if (div_ok) div_q <= DIV_W'(i_PWDATA);
      if (stat_rd) begin
        ovf_q  <= 1'b0;
        done_q <= 1'b0;
      end
      if (trail_end & rx_full)  ovf_q  <= 1'b1;
      if (trail_end & tx_empty) done_q <= 1'b1;
    end
  end

  // TX FIFO storage
  always_ff @(posedge i_PCLK) begin
    if (tx_push) tx_mem[tx_wp_q] <= i_PWDATA;
  end

  // TX FIFO pointers
  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
    end else if (flush) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
      tx_cnt_q <= tx_cnt_q + (AW + 1)'(tx_push) - (AW + 1)'(tx_pop);
    end
  end

  // RX FIFO storage
  always_ff @(posedge i_PCLK) begin
    if (rx_push) rx_mem[rx_wp_q] <= rxsh_q;
  end

  // RX FIFO pointers
  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else if (flush) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
      rx_cnt_q <= rx_cnt_q + (AW + 1)'(rx_push) - (AW + 1)'(rx_pop);
    end
  end

  // Transfer FSM with registered SCK, MOSI and chip selects
  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      half_q  <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= '1;
      txsh_q  <= '0;
      rxsh_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sck_q <= cpol_q;
          tmr_q <= '0;
          if (start_go) begin
            state_q <= S_LEAD;
            cs_n_q  <= ~sel_dec;
          end
        end
        S_LEAD: begin
          if (tmr_end) begin
            tmr_q   <= '0;
            half_q  <= '0;
            state_q <= S_SHIFT;
          end else begin
            tmr_q <= tmr_q + DIV_W'(1);
          end
        end
        S_SHIFT: begin
          if (tmr_end) begin
            tmr_q <= '0;
            sck_q <= ~sck_q;
            if (sample_now) rxsh_q <= {rxsh_q[DATA_W-2:0], i_MISO};
            if (shift_now) begin
              mosi_q <= txsh_q[DATA_W-1];
              txsh_q <= txsh_q << 1;
            end
            if (half_q == LAST_HALF) state_q <= S_TRAIL;
            else                     half_q  <= half_q + HW'(1);
          end else begin
            tmr_q <= tmr_q + DIV_W'(1);
          end
        end
        S_TRAIL: begin
          if (tmr_end) begin
            tmr_q <= '0;
            if (tx_empty) begin
              state_q <= S_IDLE;
              cs_n_q  <= '1;
            end else begin
              state_q <= S_LEAD;
            end
          end else begin
            tmr_q <= tmr_q + DIV_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Fetch the next word; with CPHA=0 its MSB is presented before the first edge
      if (load_go) begin
        txsh_q <= cpha_q ? tx_head : (tx_head << 1);
        if (!cpha_q) mosi_q <= tx_head[DATA_W-1];
      end
    end
  end

endmodule

// File: tb/tb_apb_spi_master_n.sv
// Directed bench for apb_spi_master_n: APB register access, SPI modes,
// bursts, FIFO limits, error responses and asynchronous reset.
`timescale 1ns/1ps
module tb_apb_spi_master_n;

  localparam logic [9:0] BASE = 10'h2A3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [15:0] paddr = '0;
  logic [7:0] pwdata = '0;
  logic [7:0] prdata;
  logic       pready, pslverr, sck, mosi, miso, irq;
  logic [3:0] cs_n;
  logic       lb = 1'b1;
  logic       slv_miso = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  assign miso = lb ? mosi : slv_miso;

  always #5 clk = ~clk;

  apb_spi_master_n #(.NUM_SLAVES(4), .DATA_W(8), .FIFO_DEPTH(4), .DIV_W(8)) dut (
    .i_PCLK(clk), .i_PRESETn(rst_n), .i_PSEL(psel), .i_PENABLE(penable),
    .i_PWRITE(pwrite), .i_PADDR(paddr), .i_PWDATA(pwdata), .i_BASE_ADDR(BASE),
    .o_PRDATA(prdata), .o_PREADY(pready), .o_PSLVERR(pslverr), .o_SCK(sck),
    .o_MOSI(mosi), .i_MISO(miso), .o_CS_N(cs_n), .o_IRQ(irq)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] reg_addr(input logic [3:0] off);
    return {BASE, off, 2'b00};
  endfunction

  task automatic apb(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                     output logic [7:0] rd, output logic err, output logic rdy);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    rd = prdata; err = pslverr; rdy = pready;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    $display("apb %s addr=0x%04h wdata=0x%02h rdata=0x%02h err=%0b rdy=%0b",
             wr ? "wr" : "rd", addr, wd, rd, err, rdy);
  endtask

  task automatic reg_wr(input logic [3:0] off, input logic [7:0] d, output logic err);
    logic [7:0] r;
    logic y;
    apb(1'b1, reg_addr(off), d, r, err, y);
  endtask

  task automatic reg_rd(input logic [3:0] off, output logic [7:0] d, output logic err);
    logic y;
    apb(1'b0, reg_addr(off), 8'h00, d, err, y);
  endtask

  // Follows one CS-low window: counts low cycles and SCK pulses, checks the
  // SCK period inside each frame, captures MOSI on the CPHA sample edge and
  // plays an SPI slave returning pat on MISO.
  task automatic watch(input int slot, input logic cpol, input logic cpha,
                       input logic [7:0] pat, input int halfp,
                       output int cs_low, output int pulses, output int bad_per,
                       output logic [31:0] cap);
    logic [3:0] sel_n;
    logic sck_prev, lead, trail, started, fin;
    int last_lead, bitcnt;
    sel_n = ~(4'b0001 << slot);
    cs_low = 0; pulses = 0; bad_per = 0; cap = '0;
    sck_prev = cpol; started = 1'b0; fin = 1'b0; last_lead = 0; bitcnt = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (cs_n == sel_n) begin
        cs_low++;
        if (!started) begin
          started = 1'b1;
          slv_miso = pat[7];
        end
      end else if (cs_n == 4'hF && started) begin
        fin = 1'b1;
        break;
      end
      lead  = (sck_prev == cpol) && (sck != cpol);
      trail = (sck_prev != cpol) && (sck == cpol);
      if (lead) begin
        if ((pulses % 8) != 0 && (cyc - last_lead) != 2 * halfp) bad_per++;
        last_lead = cyc;
        pulses++;
      end
      if (cpha ? trail : lead) cap = {cap[30:0], mosi};
      if (cpha ? lead : trail) begin
        if (cpha) begin
          slv_miso = pat[7 - (bitcnt % 8)];
          bitcnt++;
        end else begin
          bitcnt++;
          slv_miso = pat[7 - (bitcnt % 8)];
        end
      end
      sck_prev = sck;
    end
    check_eq("watch_done", fin, 1'b1);
  endtask

  logic [7:0] mode_cfg [3] = '{8'h01, 8'h06, 8'h0B};
  logic [7:0] mode_tx  [3] = '{8'h96, 8'h5A, 8'hC3};
  logic [7:0] burst_tx [4] = '{8'h01, 8'h23, 8'h45, 8'h67};

  initial begin
    logic [7:0] d, cfg;
    logic e, y;
    int csl, pul, bp, k;
    logic [31:0] mc;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cs", cs_n, 4'hF);
    check_eq("rst_sck", sck, 1'b0);
    check_eq("rst_mosi", mosi, 1'b0);
    check_eq("rst_irq", irq, 1'b0);
    check_eq("rst_pready", pready, 1'b0);
    check_eq("rst_pslverr", pslverr, 1'b0);
    check_eq("rst_prdata", prdata, 8'h00);
    rst_n = 1'b1;
    reg_rd(4'd0, d, e);
    check_eq("rst_status", d, 8'h0A);
    reg_rd(4'd2, d, e);
    check_eq("rst_div", d, 8'h01);

    // Empty RX read, unmapped offset, foreign base address
    reg_rd(4'd1, d, e);
    check_eq("rx_empty_data", d, 8'h00);
    check_eq("rx_empty_err", e, 1'b1);
    reg_rd(4'd5, d, e);
    check_eq("unmapped_data", d, 8'h00);
    check_eq("unmapped_err", e, 1'b0);
    apb(1'b0, {BASE + 10'd1, 4'd0, 2'b00}, 8'h00, d, e, y);
    check_eq("miss_ready", y, 1'b0);

    // Mode 0 loopback on slave 3, bad slave index rejected
    reg_wr(4'd0, 8'h0C, e);
    check_eq("cfg_ok_err", e, 1'b0);
    reg_wr(4'd0, 8'h14, e);
    check_eq("cfg_idx_err", e, 1'b1);
    reg_wr(4'd2, 8'h01, e);
    reg_wr(4'd1, 8'hA5, e);
    check_eq("tx_push_err", e, 1'b0);
    lb = 1'b1;
    reg_wr(4'd3, 8'h02, e);
    check_eq("start_err", e, 1'b0);
    watch(3, 1'b0, 1'b0, 8'h00, 2, csl, pul, bp, mc);
    check_eq("m0_cs_cycles", csl, 36);
    check_eq("m0_pulses", pul, 8);
    check_eq("m0_period", bp, 0);
    check_eq("m0_mosi", mc[7:0], 8'hA5);
    check_eq("m0_sck_idle", sck, 1'b0);
    check_eq("m0_irq_set", irq, 1'b1);
    reg_rd(4'd1, d, e);
    check_eq("m0_rx", d, 8'hA5);
    reg_rd(4'd0, d, e);
    check_eq("m0_status", d, 8'h4A);
    @(negedge clk);
    check_eq("m0_irq_clr", irq, 1'b0);

    // Modes 1..3 against a slave returning 0x3C
    lb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cfg = mode_cfg[i];
      reg_wr(4'd0, cfg, e);
      reg_wr(4'd1, mode_tx[i], e);
      @(negedge clk);
      check_eq($sformatf("mode%0d_sck_idle_pre", i + 1), sck, cfg[1]);
      reg_wr(4'd3, 8'h02, e);
      watch(int'(cfg[7:2]), cfg[1], cfg[0], 8'h3C, 2, csl, pul, bp, mc);
      check_eq($sformatf("mode%0d_cs_cycles", i + 1), csl, 36);
      check_eq($sformatf("mode%0d_pulses", i + 1), pul, 8);
      check_eq($sformatf("mode%0d_mosi", i + 1), mc[7:0], mode_tx[i]);
      check_eq($sformatf("mode%0d_sck_idle_post", i + 1), sck, cfg[1]);
      reg_rd(4'd1, d, e);
      check_eq($sformatf("mode%0d_rx", i + 1), d, 8'h3C);
      reg_rd(4'd0, d, e);
      check_eq($sformatf("mode%0d_status", i + 1), d, 8'h4A);
    end

    // DIV=0: fastest SCK, half-period of one PCLK cycle
    lb = 1'b1;
    reg_wr(4'd0, 8'h0C, e);
    reg_wr(4'd2, 8'h00, e);
    reg_wr(4'd1, 8'h3A, e);
    reg_wr(4'd3, 8'h02, e);
    watch(3, 1'b0, 1'b0, 8'h00, 1, csl, pul, bp, mc);
    check_eq("div0_cs_cycles", csl, 18);
    check_eq("div0_period", bp, 0);
    check_eq("div0_mosi", mc[7:0], 8'h3A);
    reg_rd(4'd1, d, e);
    check_eq("div0_rx", d, 8'h3A);
    reg_rd(4'd0, d, e);
    check_eq("div0_status", d, 8'h4A);

    // Accesses while busy are rejected
    reg_wr(4'd2, 8'h03, e);
    reg_wr(4'd0, 8'h04, e);
    reg_wr(4'd1, 8'h11, e);
    reg_wr(4'd3, 8'h02, e);
    @(negedge clk);
    check_eq("busy_cs", cs_n, 4'hD);
    reg_wr(4'd2, 8'h05, e);
    check_eq("busy_div_err", e, 1'b1);
    reg_wr(4'd0, 8'h08, e);
    check_eq("busy_cfg_err", e, 1'b1);
    reg_wr(4'd3, 8'h01, e);
    check_eq("busy_cmd_err", e, 1'b1);
    reg_rd(4'd0, d, e);
    check_eq("busy_status", d, 8'h0B);
    k = 0;
    do begin
      reg_rd(4'd0, d, e);
      k++;
    end while (d[0] && k < 100);
    check_eq("busy_clear", d[0], 1'b0);
    check_eq("busy_end_status", d, 8'h42);
    reg_rd(4'd2, d, e);
    check_eq("busy_div_kept", d, 8'h03);
    reg_rd(4'd1, d, e);
    check_eq("busy_rx", d, 8'h11);

    // Four-word burst, TX full, then an extra frame into a full RX
    reg_wr(4'd2, 8'h01, e);
    reg_wr(4'd0, 8'h0C, e);
    reg_rd(4'd0, d, e);
    check_eq("burst_pre_status", d, 8'h0A);
    for (int i = 0; i < 4; i++) reg_wr(4'd1, burst_tx[i], e);
    reg_rd(4'd0, d, e);
    check_eq("burst_tx_full", d, 8'h0C);
    reg_wr(4'd1, 8'h89, e);
    check_eq("burst_push_full_err", e, 1'b1);
    reg_wr(4'd3, 8'h02, e);
    watch(3, 1'b0, 1'b0, 8'h00, 2, csl, pul, bp, mc);
    check_eq("burst_cs_cycles", csl, 144);
    check_eq("burst_pulses", pul, 32);
    check_eq("burst_period", bp, 0);
    check_eq("burst_mosi", mc, 32'h01234567);
    reg_rd(4'd0, d, e);
    check_eq("burst_status", d, 8'h52);
    reg_wr(4'd1, 8'h89, e);
    reg_wr(4'd3, 8'h02, e);
    watch(3, 1'b0, 1'b0, 8'h00, 2, csl, pul, bp, mc);
    check_eq("ovf_cs_cycles", csl, 36);
    check_eq("ovf_irq", irq, 1'b1);
    reg_rd(4'd0, d, e);
    check_eq("ovf_status", d, 8'h72);
    @(negedge clk);
    check_eq("ovf_irq_clr", irq, 1'b0);
    for (int i = 0; i < 4; i++) begin
      reg_rd(4'd1, d, e);
      check_eq($sformatf("burst_rx%0d", i), d, burst_tx[i]);
    end
    reg_rd(4'd1, d, e);
    check_eq("burst_rx_empty_err", e, 1'b1);

    // START together with FLUSH: flush wins, nothing is sent
    reg_wr(4'd1, 8'hAA, e);
    reg_wr(4'd3, 8'h03, e);
    check_eq("flush_err", e, 1'b0);
    @(negedge clk);
    check_eq("flush_cs", cs_n, 4'hF);
    reg_rd(4'd0, d, e);
    check_eq("flush_status", d, 8'h0A);

    // Asynchronous reset in the middle of a CPOL=1 frame
    reg_wr(4'd0, 8'h02, e);
    reg_wr(4'd1, 8'h55, e);
    reg_wr(4'd3, 8'h02, e);
    @(negedge clk);
    check_eq("arst_cs_before", cs_n, 4'hE);
    check_eq("arst_sck_before", sck, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_cs", cs_n, 4'hF);
    check_eq("arst_sck", sck, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reg_rd(4'd0, d, e);
    check_eq("arst_status", d, 8'h0A);
    reg_rd(4'd2, d, e);
    check_eq("arst_div", d, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
